// File: rtl/nx_indirect_access_sequencer_if.sv
// Request/response and register-bus interfaces for the indirect-access
// sequencer. The sequencer is the slave on req and the master on reg.
interface nx_ias_req_if #(
    parameter int N_DATA_WORDS = 1,
    parameter int N_ADDR_BITS  = 10,
    parameter int N_TABLE_BITS = 1
);
    logic                        req_valid;
    logic                        req_ready;
    logic [3:0]                  req_op;
    logic [N_ADDR_BITS-1:0]      req_addr;
    logic [N_TABLE_BITS-1:0]     req_table_id;
    logic [32*N_DATA_WORDS-1:0]  req_wdat;
    logic                        rsp_valid;
    logic                        rsp_ready;
    logic [2:0]                  rsp_code;
    logic                        rsp_poll_tmo;
    logic [32*N_DATA_WORDS-1:0]  rsp_rdat;

    modport master (
        output req_valid, req_op, req_addr, req_table_id, req_wdat,
        output rsp_ready,
        input  req_ready, rsp_valid, rsp_code, rsp_poll_tmo, rsp_rdat
    );
    modport slave (
        input  req_valid, req_op, req_addr, req_table_id, req_wdat,
        input  rsp_ready,
        output req_ready, rsp_valid, rsp_code, rsp_poll_tmo, rsp_rdat
    );
endinterface

interface nx_ias_reg_if #(
    parameter int N_REG_ADDR_BITS = 16
);
    logic                        reg_wr;
    logic                        reg_rd;
    logic [N_REG_ADDR_BITS-1:0]  reg_addr;
    logic [31:0]                 reg_wdat;
    logic [31:0]                 reg_rdat;
    logic                        reg_ack;

    modport master (
        output reg_wr, reg_rd, reg_addr, reg_wdat,
        input  reg_rdat, reg_ack
    );
    modport slave (
        input  reg_wr, reg_rd, reg_addr, reg_wdat,
        output reg_rdat, reg_ack
    );
endinterface

// File: rtl/nx_indirect_access_sequencer.sv
// Turns one memory-access request into the register-bus sequence of the
// indirect-access protocol: data writes, command, status poll, read-back.
module nx_indirect_access_sequencer #(
    parameter int CMND_ADDRESS    = 0,
    parameter int STAT_ADDRESS    = 0,
    parameter int DATA_ADDRESS    = 0,
    parameter int ALIGNMENT       = 2,
    parameter int N_REG_ADDR_BITS = 16,
    parameter int N_DATA_WORDS    = 1,
    parameter int N_ADDR_BITS     = 10,
    parameter int N_TABLE_BITS    = 1,
    parameter int N_POLL_BITS     = 8,
    parameter int POLL_GAP        = 2,
    parameter int AUTO_ACK        = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    nx_ias_req_if.slave   req,
    nx_ias_reg_if.master  bus,
    output logic          busy
);

    localparam int DW       = 32 * N_DATA_WORDS;
    localparam int IW       = (N_DATA_WORDS > 1) ? $clog2(N_DATA_WORDS) : 1;
    localparam int GW       = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
    localparam int GAP_LAST = (POLL_GAP > 0) ? POLL_GAP - 1 : 0;

    localparam logic [IW-1:0] LAST_IDX = IW'(N_DATA_WORDS - 1);
    localparam logic [GW-1:0] GAP_END  = GW'(GAP_LAST);

    localparam logic [N_REG_ADDR_BITS-1:0] A_CMND = N_REG_ADDR_BITS'(CMND_ADDRESS);
    localparam logic [N_REG_ADDR_BITS-1:0] A_STAT = N_REG_ADDR_BITS'(STAT_ADDRESS);

    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_READ  = 4'h1;
    localparam logic [3:0] OP_WRITE = 4'h2;
    localparam logic [3:0] OP_INIT  = 4'h6;
    localparam logic [3:0] OP_INCR  = 4'h7;
    localparam logic [3:0] OP_CMPR  = 4'h9;
    localparam logic [3:0] OP_ACK   = 4'hF;

    localparam logic [2:0] ST_RDY = 3'd0;
    localparam logic [2:0] ST_BSY = 3'd1;
    localparam logic [2:0] ST_PDN = 3'd7;

    typedef enum logic [2:0] {
        S_IDLE, S_WR_DATA, S_WR_CMND, S_RD_STAT,
        S_GAP, S_RD_DATA, S_ACK_ERR, S_RESP
    } state_t;

    state_t                     r_state, w_state;
    logic                       r_wr, w_wr;
    logic                       r_rd, w_rd;
    logic [N_REG_ADDR_BITS-1:0] r_addr, w_addr;
    logic [31:0]                r_wdat, w_wdat;
    logic [IW-1:0]              r_idx, w_idx;
    logic [N_POLL_BITS-1:0]     r_poll, w_poll;
    logic [GW-1:0]              r_gap, w_gap;
    logic [2:0]                 r_code, w_code;
    logic                       r_tmo, w_tmo;
    logic [DW-1:0]              r_rdat, w_rdat;
    logic                       r_rsp_valid, w_rsp_valid;
    logic                       r_busy;

    logic [3:0]                 r_op;
    logic [N_ADDR_BITS-1:0]     r_eaddr;
    logic [N_TABLE_BITS-1:0]    r_tbl;
    logic [DW-1:0]              r_wbuf;

    logic                       w_accept;
    logic                       w_ack;
    logic [2:0]                 w_stat;

    function automatic logic [N_REG_ADDR_BITS-1:0] f_daddr(input logic [IW-1:0] i);
        logic [31:0] a;
        a = 32'(DATA_ADDRESS) + (32'(i) << ALIGNMENT);
        return a[N_REG_ADDR_BITS-1:0];
    endfunction

    function automatic logic [31:0] f_cmd(
        input logic [3:0]              op,
        input logic [N_TABLE_BITS-1:0] t,
        input logic [N_ADDR_BITS-1:0]  a
    );
        logic [31:0] c;
        c = '0;
        c[31:28] = op;
        c[16 +: N_TABLE_BITS] = t;
        c[N_ADDR_BITS-1:0] = a;
        return c;
    endfunction

    function automatic logic [31:0] f_word(input logic [DW-1:0] v, input logic [IW-1:0] i);
        return v[{i, 5'd0} +: 32];
    endfunction

    function automatic logic f_is_wr(input logic [3:0] op);
        return (op == OP_WRITE) || (op == OP_INIT) || (op == OP_INCR);
    endfunction

    function automatic logic f_is_rb(input logic [3:0] op);
        return (op == OP_READ) || (op == OP_CMPR);
    endfunction

    assign w_accept = req.req_valid && (r_state == S_IDLE);
    // Acks with no strobe outstanding are stray and must not advance anything.
    assign w_ack    = bus.reg_ack && (r_wr || r_rd);
    assign w_stat   = bus.reg_rdat[31:29];

    always_comb begin
        w_state     = r_state;
        w_wr        = r_wr;
        w_rd        = r_rd;
        w_addr      = r_addr;
        w_wdat      = r_wdat;
        w_idx       = r_idx;
        w_poll      = r_poll;
        w_gap       = r_gap;
        w_code      = r_code;
        w_tmo       = r_tmo;
        w_rdat      = r_rdat;
        w_rsp_valid = r_rsp_valid;
        unique case (r_state)
            S_IDLE: if (req.req_valid) begin
                w_idx = '0;
                unique case (1'b1)
                    (req.req_op == OP_NOP): begin
                        w_state     = S_RESP;
                        w_rsp_valid = 1'b1;
                        w_code      = ST_RDY;
                    end
                    f_is_wr(req.req_op): begin
                        w_state = S_WR_DATA;
                        w_wr    = 1'b1;
                        w_addr  = f_daddr('0);
                        w_wdat  = req.req_wdat[31:0];
                    end
                    default: begin
                        w_state = S_WR_CMND;
                        w_wr    = 1'b1;
                        w_addr  = A_CMND;
                        w_wdat  = f_cmd(req.req_op, req.req_table_id, req.req_addr);
                    end
                endcase
            end
            S_WR_DATA: if (w_ack) begin
                if (r_idx == LAST_IDX) begin
                    w_state = S_WR_CMND;
                    w_addr  = A_CMND;
                    w_wdat  = f_cmd(r_op, r_tbl, r_eaddr);
                end else begin
                    w_idx  = r_idx + 1'b1;
                    w_addr = f_daddr(w_idx);
                    w_wdat = f_word(r_wbuf, w_idx);
                end
            end
            S_WR_CMND: if (w_ack) begin
                w_state = S_RD_STAT;
                w_wr    = 1'b0;
                w_rd    = 1'b1;
                w_addr  = A_STAT;
                w_wdat  = '0;
                w_poll  = '0;
            end
            S_RD_STAT: if (w_ack) begin
                unique case (1'b1)
                    (w_stat == ST_BSY) && !(&r_poll): begin
                        w_poll = r_poll + 1'b1;
                        // With no gap the strobe simply stays up for the next poll.
                        if (POLL_GAP != 0) begin
                            w_rd    = 1'b0;
                            w_state = S_GAP;
                            w_gap   = '0;
                        end
                    end
                    (w_stat == ST_BSY) && (&r_poll): begin
                        w_rd        = 1'b0;
                        w_tmo       = 1'b1;
                        w_code      = ST_BSY;
                        w_state     = S_RESP;
                        w_rsp_valid = 1'b1;
                    end
                    (w_stat == ST_RDY) || (w_stat == ST_PDN): begin
                        w_code = w_stat;
                        if (f_is_rb(r_op)) begin
                            w_state = S_RD_DATA;
                            w_idx   = '0;
                            w_addr  = f_daddr('0);
                        end else begin
                            w_rd        = 1'b0;
                            w_state     = S_RESP;
                            w_rsp_valid = 1'b1;
                        end
                    end
                    default: begin
                        w_code = w_stat;
                        w_rd   = 1'b0;
                        if (AUTO_ACK != 0) begin
                            w_state = S_ACK_ERR;
                            w_wr    = 1'b1;
                            w_addr  = A_CMND;
                            w_wdat  = f_cmd(OP_ACK, '0, '0);
                        end else begin
                            w_state     = S_RESP;
                            w_rsp_valid = 1'b1;
                        end
                    end
                endcase
            end
            S_GAP: begin
                if (r_gap == GAP_END) begin
                    w_state = S_RD_STAT;
                    w_rd    = 1'b1;
                end else begin
                    w_gap = r_gap + 1'b1;
                end
            end
            S_RD_DATA: if (w_ack) begin
                w_rdat[{r_idx, 5'd0} +: 32] = bus.reg_rdat;
                if (r_idx == LAST_IDX) begin
                    w_rd        = 1'b0;
                    w_state     = S_RESP;
                    w_rsp_valid = 1'b1;
                end else begin
                    w_idx  = r_idx + 1'b1;
                    w_addr = f_daddr(w_idx);
                end
            end
            S_ACK_ERR: if (w_ack) begin
                w_wr        = 1'b0;
                w_state     = S_RESP;
                w_rsp_valid = 1'b1;
            end
            S_RESP: if (req.rsp_ready) begin
                w_state     = S_IDLE;
                w_rsp_valid = 1'b0;
                w_code      = '0;
                w_tmo       = 1'b0;
                w_rdat      = '0;
            end
            default: w_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_wr        <= 1'b0;
            r_rd        <= 1'b0;
            r_addr      <= '0;
            r_wdat      <= '0;
            r_idx       <= '0;
            r_poll      <= '0;
            r_gap       <= '0;
            r_code      <= '0;
            r_tmo       <= 1'b0;
            r_rdat      <= '0;
            r_rsp_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_wr        <= w_wr;
            r_rd        <= w_rd;
            r_addr      <= w_addr;
            r_wdat      <= w_wdat;
            r_idx       <= w_idx;
            r_poll      <= w_poll;
            r_gap       <= w_gap;
            r_code      <= w_code;
            r_tmo       <= w_tmo;
            r_rdat      <= w_rdat;
            r_rsp_valid <= w_rsp_valid;
            r_busy      <= (w_state != S_IDLE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op    <= '0;
            r_eaddr <= '0;
            r_tbl   <= '0;
            r_wbuf  <= '0;
        end else if (w_accept) begin
            r_op    <= req.req_op;
            r_eaddr <= req.req_addr;
            r_tbl   <= req.req_table_id;
            r_wbuf  <= req.req_wdat;
        end
    end

    assign req.req_ready    = (r_state == S_IDLE);
    assign req.rsp_valid    = r_rsp_valid;
    assign req.rsp_code     = r_code;
    assign req.rsp_poll_tmo = r_tmo;
    assign req.rsp_rdat     = r_rdat;
    assign bus.reg_wr       = r_wr;
    assign bus.reg_rd       = r_rd;
    assign bus.reg_addr     = r_addr;
    assign bus.reg_wdat     = r_wdat;
    assign busy             = r_busy;

endmodule

// File: tb/tb_nx_indirect_access_sequencer.sv
// Directed bench: a register-bus responder logs every transaction and the
// stimulus compares logs and responses against hand-computed vectors.
module tb_nx_indirect_access_sequencer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic busy;
    always #5 clk = ~clk;

    nx_ias_req_if #(.N_DATA_WORDS(2), .N_ADDR_BITS(10), .N_TABLE_BITS(4)) rq ();
    nx_ias_reg_if #(.N_REG_ADDR_BITS(16)) rb ();

    nx_indirect_access_sequencer #(
        .CMND_ADDRESS(32'h10), .STAT_ADDRESS(32'h14), .DATA_ADDRESS(32'h20),
        .ALIGNMENT(2), .N_REG_ADDR_BITS(16), .N_DATA_WORDS(2),
        .N_ADDR_BITS(10), .N_TABLE_BITS(4), .N_POLL_BITS(2),
        .POLL_GAP(2), .AUTO_ACK(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req(rq), .bus(rb), .busy(busy)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int t0 = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          ack_dly = 0;
    logic [31:0] stat_default = 32'h0;
    logic [31:0] stat_q[$];
    logic [31:0] data_w[2];
    logic [63:0] txq[$];
    logic [63:0] exq[$];
    int          stab_err = 0;
    bit          in_txn = 0;
    int          wcnt = 0;
    logic [3:0]  t_kind;
    logic [15:0] t_addr;
    logic [31:0] t_wdat;
    int          t_cyc;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] tx(int c, logic [3:0] k, logic [15:0] a, logic [31:0] d);
        return {8'(c), k, 4'h0, a, d};
    endfunction

    function automatic logic [31:0] rd_val(logic [15:0] a);
        int di;
        if (a == 16'h14) begin
            if (stat_q.size() > 0) return stat_q.pop_front();
            return stat_default;
        end
        di = (int'(a) - 32) / 4;
        if (di >= 0 && di < 2) return data_w[di];
        return 32'hBAD0BAD0;
    endfunction

    // Responder: decides and logs on the falling edge, DUT samples on the rising one.
    always @(negedge clk) begin
        if (!rst_n) begin
            rb.reg_ack = 1'b0;
            rb.reg_rdat = '0;
            in_txn = 0;
            wcnt = 0;
        end else begin
            if (rb.reg_ack) begin
                rb.reg_ack = 1'b0;
                in_txn = 0;
            end
            if (rb.reg_wr && rb.reg_rd) stab_err++;
            if (rb.reg_wr || rb.reg_rd) begin
                if (!in_txn) begin
                    in_txn = 1;
                    wcnt = 0;
                    t_kind = rb.reg_wr ? 4'd1 : 4'd2;
                    t_addr = rb.reg_addr;
                    t_wdat = rb.reg_wdat;
                    t_cyc = cyc - t0;
                end else if (t_addr != rb.reg_addr ||
                             t_kind != (rb.reg_wr ? 4'd1 : 4'd2) ||
                             (rb.reg_wr && t_wdat != rb.reg_wdat)) begin
                    stab_err++;
                end
                if (wcnt == ack_dly) begin
                    rb.reg_ack = 1'b1;
                    rb.reg_rdat = rb.reg_rd ? rd_val(t_addr) : 32'h0;
                    txq.push_back(tx(t_cyc, t_kind, t_addr, rb.reg_wr ? t_wdat : 32'h0));
                end else begin
                    wcnt++;
                end
            end
        end
    end

    function automatic logic [127:0] outs();
        return {7'b0, rq.req_ready, busy, rq.rsp_valid, rq.rsp_code, rq.rsp_poll_tmo,
                rq.rsp_rdat, rb.reg_wr, rb.reg_rd, rb.reg_addr, rb.reg_wdat};
    endfunction

    task automatic chk_bus(input string tag);
        chk({tag, ".ntx"}, 128'(txq.size()), 128'(exq.size()));
        foreach (exq[i])
            chk($sformatf("%s.tx%0d", tag, i),
                (i < txq.size()) ? 128'(txq[i]) : {128{1'b1}}, 128'(exq[i]));
        txq.delete();
        exq.delete();
    endtask

    task automatic send(input logic [3:0] op, input logic [9:0] a,
                        input logic [3:0] t, input logic [63:0] wd);
        int n;
        rq.req_op = op;
        rq.req_addr = a;
        rq.req_table_id = t;
        rq.req_wdat = wd;
        rq.req_valid = 1'b1;
        n = 0;
        while (!rq.req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!rq.req_ready) chk("send.timeout", 0, 1);
        t0 = cyc;
        @(negedge clk);
        rq.req_valid = 1'b0;
    endtask

    task automatic wait_rsp(input string tag, output int lat);
        int n;
        n = 0;
        while (!rq.rsp_valid && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!rq.rsp_valid) chk({tag, ".timeout"}, 0, 1);
        lat = cyc - t0;
    endtask

    task automatic finish_rsp(input string tag);
        rq.rsp_ready = 1'b1;
        @(negedge clk);
        rq.rsp_ready = 1'b0;
        chk({tag, ".clr"}, {rq.rsp_valid, rq.rsp_code, rq.rsp_poll_tmo, rq.req_ready},
            {1'b0, 3'd0, 1'b0, 1'b1});
    endtask

    task automatic check_rsp(input string tag, input int lat_e, input logic [2:0] code_e,
                             input logic tmo_e, input logic [63:0] rdat_e);
        int lat;
        wait_rsp(tag, lat);
        chk({tag, ".lat"}, 128'(lat), 128'(lat_e));
        chk({tag, ".code"}, 128'(rq.rsp_code), 128'(code_e));
        chk({tag, ".tmo"}, 128'(rq.rsp_poll_tmo), 128'(tmo_e));
        chk({tag, ".rdat"}, 128'(rq.rsp_rdat), 128'(rdat_e));
        chk({tag, ".busy"}, 128'(busy), 128'(1));
        finish_rsp(tag);
    endtask

    initial begin
        int lat;
        int bad;
        int n;
        rq.req_valid = 1'b0;
        rq.req_op = '0;
        rq.req_addr = '0;
        rq.req_table_id = '0;
        rq.req_wdat = '0;
        rq.rsp_ready = 1'b0;
        data_w[0] = 32'h0;
        data_w[1] = 32'h0;
        repeat (3) @(negedge clk);
        chk("reset.outs", outs(), {7'b0, 1'b1, 120'b0});
        rst_n = 1'b1;
        @(negedge clk);

        // WRITE, two words, zero-wait, first poll RDY
        stat_q.push_back(32'h0);
        send(4'h2, 10'h005, 4'h0, {32'h12345678, 32'hDEADBEEF});
        check_rsp("write", 5, 3'd0, 1'b0, 64'h0);
        exq.push_back(tx(1, 1, 16'h20, 32'hDEADBEEF));
        exq.push_back(tx(2, 1, 16'h24, 32'h12345678));
        exq.push_back(tx(3, 1, 16'h10, 32'h20000005));
        exq.push_back(tx(4, 2, 16'h14, 32'h0));
        chk_bus("write");

        // READ with two BSY polls spaced by the poll gap
        stat_q.push_back(32'h20000000);
        stat_q.push_back(32'h20000000);
        stat_q.push_back(32'h00000000);
        data_w[0] = 32'h11;
        data_w[1] = 32'h22;
        send(4'h1, 10'h003, 4'h2, 64'h0);
        check_rsp("read", 11, 3'd0, 1'b0, 64'h00000022_00000011);
        exq.push_back(tx(1, 1, 16'h10, 32'h10020003));
        exq.push_back(tx(2, 2, 16'h14, 32'h0));
        exq.push_back(tx(5, 2, 16'h14, 32'h0));
        exq.push_back(tx(8, 2, 16'h14, 32'h0));
        exq.push_back(tx(9, 2, 16'h20, 32'h0));
        exq.push_back(tx(10, 2, 16'h24, 32'h0));
        chk_bus("read");

        // NXM status is acknowledged automatically
        stat_q.push_back(32'h80000000);
        send(4'h4, 10'h000, 4'h0, 64'h0);
        check_rsp("nxm", 4, 3'd4, 1'b0, 64'h0);
        exq.push_back(tx(1, 1, 16'h10, 32'h40000000));
        exq.push_back(tx(2, 2, 16'h14, 32'h0));
        exq.push_back(tx(3, 1, 16'h10, 32'hF0000000));
        chk_bus("nxm");

        // Controller stuck BSY: poll limit of 4 reads
        stat_default = 32'h20000000;
        send(4'h3, 10'h1FF, 4'hF, 64'h0);
        check_rsp("ptmo", 12, 3'd1, 1'b1, 64'h0);
        exq.push_back(tx(1, 1, 16'h10, 32'h300F01FF));
        exq.push_back(tx(2, 2, 16'h14, 32'h0));
        exq.push_back(tx(5, 2, 16'h14, 32'h0));
        exq.push_back(tx(8, 2, 16'h14, 32'h0));
        exq.push_back(tx(11, 2, 16'h14, 32'h0));
        chk_bus("ptmo");
        stat_default = 32'h0;

        // PDN status still reads back data
        stat_q.push_back(32'hE0000000);
        data_w[0] = 32'hA5A5A5A5;
        data_w[1] = 32'h5A5A5A5A;
        send(4'h9, 10'h010, 4'h1, 64'h0);
        check_rsp("pdn", 5, 3'd7, 1'b0, 64'h5A5A5A5A_A5A5A5A5);
        exq.push_back(tx(1, 1, 16'h10, 32'h90010010));
        exq.push_back(tx(2, 2, 16'h14, 32'h0));
        exq.push_back(tx(3, 2, 16'h20, 32'h0));
        exq.push_back(tx(4, 2, 16'h24, 32'h0));
        chk_bus("pdn");

        // Slow acks, held response, competing request
        ack_dly = 3;
        stab_err = 0;
        stat_q.push_back(32'h0);
        send(4'h7, 10'h2AA, 4'h5, {32'h0BADC0DE, 32'hCAFEF00D});
        wait_rsp("slow", lat);
        chk("slow.lat", 128'(lat), 128'(17));
        rq.req_op = 4'h0;
        rq.req_valid = 1'b1;
        bad = 0;
        repeat (5) begin
            @(negedge clk);
            if (!rq.rsp_valid || rq.req_ready || !busy) bad++;
        end
        chk("slow.hold", 128'(bad), 128'(0));
        chk("slow.code", 128'(rq.rsp_code), 128'(0));
        rq.rsp_ready = 1'b1;
        @(negedge clk);
        rq.rsp_ready = 1'b0;
        chk("slow.stable", 128'(stab_err), 128'(0));
        exq.push_back(tx(1, 1, 16'h20, 32'hCAFEF00D));
        exq.push_back(tx(5, 1, 16'h24, 32'h0BADC0DE));
        exq.push_back(tx(9, 1, 16'h10, 32'h700502AA));
        exq.push_back(tx(13, 2, 16'h14, 32'h0));
        chk_bus("slow");
        send(4'h0, 10'h000, 4'h0, 64'h0);
        check_rsp("nop", 1, 3'd0, 1'b0, 64'h0);
        chk_bus("nop");
        ack_dly = 0;

        // Reset in the middle of status polling
        stat_default = 32'h20000000;
        send(4'h3, 10'h001, 4'h0, 64'h0);
        n = 0;
        while (!rb.reg_rd && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("rst.reach_stat", 128'(rb.reg_rd), 128'(1));
        #1 rst_n = 1'b0;
        @(negedge clk);
        chk("rst.outs", outs(), {7'b0, 1'b1, 120'b0});
        #1 rst_n = 1'b1;
        @(negedge clk);
        txq.delete();
        stat_default = 32'h0;
        stat_q.delete();
        stat_q.push_back(32'h0);
        send(4'h6, 10'h3FF, 4'hA, {32'hFFFFFFFF, 32'h00000000});
        check_rsp("post", 5, 3'd0, 1'b0, 64'h0);
        exq.push_back(tx(1, 1, 16'h20, 32'h00000000));
        exq.push_back(tx(2, 1, 16'h24, 32'hFFFFFFFF));
        exq.push_back(tx(3, 1, 16'h10, 32'h600A03FF));
        exq.push_back(tx(4, 2, 16'h14, 32'h0));
        chk_bus("post");
        chk("final.stable", 128'(stab_err), 128'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/nx_indirect_access_sequencer.md
# nx_indirect_access_sequencer

Hardware initiator for the indirect-access register protocol. It accepts one memory-access request at a time on a valid/ready port and turns it into a sequence of register-bus transactions against an indirect-access controller:
- write the data words;
- write the command register;
- poll the status register until the controller leaves BSY;
- read back the data words for READ/COMPARE;
- optionally acknowledge errors.

It sits between on-chip agents (init engines, firmware offload) and the per-memory indirect-access controllers on the register bus.

## Interface
- CMND_ADDRESS, 0: byte address of the command register.
- STAT_ADDRESS, 0: byte address of the status register.
- DATA_ADDRESS, 0: byte address of data word 0. Word i is at DATA_ADDRESS + (i << ALIGNMENT).
- ALIGNMENT, 2: log2 of the byte stride between registers.
- N_REG_ADDR_BITS, 16: register-bus address width.
- N_DATA_WORDS, 1: number of 32-bit data registers, 1..8.
- N_ADDR_BITS, 10: entry-address width, at most 16.
- N_TABLE_BITS, 1: table-id width, at most 12.
- N_POLL_BITS, 8: width of the status-poll counter.
- POLL_GAP, 2: idle cycles between consecutive status reads, at least 0.
- AUTO_ACK, 1: when 1, error statuses are acknowledged automatically with ACK_ERROR.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  1  request valid.
- req_ready  out  1  request accepted when high with req_valid.
- req_op  in  4  indirect-access opcode (0x0–0xF encoding).
- req_addr  in  N_ADDR_BITS  entry address.
- req_table_id  in  N_TABLE_BITS  table id.
- req_wdat  in  32*N_DATA_WORDS  write data; word 0 is in bits [31:0].
- rsp_valid  out  1  response valid; held until rsp_ready.
- rsp_ready  in  1  response consumed.
- rsp_code  out  3  final controller status: RDY=0, BSY=1, TMO=2, OVR=3, NXM=4, UOP=5, PDN=7.
- rsp_poll_tmo  out  1  the poll limit was reached while the controller was still BSY.
- rsp_rdat  out  32*N_DATA_WORDS  read-back data; zero for ops without read-back.
- reg_wr  out  1  register write strobe.
- reg_rd  out  1  register read strobe.
- reg_addr  out  N_REG_ADDR_BITS  register address.
- reg_wdat  out  32  register write data.
- reg_rdat  in  32  register read data; valid with reg_ack.
- reg_ack  in  1  transaction complete.
- busy  out  1  high in every state other than IDLE.

## Operation
- Command word layout: op in [31:28]; table id in [16+N_TABLE_BITS-1:16]; address in [N_ADDR_BITS-1:0]; all other bits zero.
- Status code is taken from reg_rdat[31:29].
- Request capture: the request is latched at req_valid && req_ready. req_ready = (state == IDLE).
- Data-writing ops: WRITE (2), INIT (6), INIT_INC (7).
- Read-back ops: READ (1), COMPARE (9).
- NOP (0) does not touch the register bus. It goes straight to RESP with rsp_code=RDY.

State machine:
- IDLE: on a captured request, go to WR_DATA for data-writing ops, RESP for NOP, WR_CMND otherwise. Word index resets to 0.
- WR_DATA: write word i to DATA_ADDRESS + (i << ALIGNMENT). On ack, increment i. After word N_DATA_WORDS-1 is acked, go to WR_CMND.
- WR_CMND: write the command word to CMND_ADDRESS. On ack, clear the poll counter and go to RD_STAT.
- RD_STAT: read STAT_ADDRESS. On ack:
  - code BSY, poll counter not all-ones: increment the counter and go to GAP.
  - code BSY, poll counter all-ones: set poll_tmo and go to RESP with rsp_code=BSY.
  - code RDY or PDN: go to RD_DATA for read-back ops with i=0, otherwise RESP.
  - any other code: latch the code and go to ACK_ERR if AUTO_ACK, otherwise RESP.
- GAP: count POLL_GAP cycles, then return to RD_STAT. With POLL_GAP=0, GAP is skipped.
- RD_DATA: read word i and store it into rsp_rdat word i on ack. After the last word, go to RESP.
- ACK_ERR: write command word with op=0xF to CMND_ADDRESS. On ack, go to RESP. rsp_code keeps the latched error code.
- RESP: hold rsp_valid=1. On rsp_ready, go to IDLE and clear the rsp fields.

Register-bus rules:
- At most one of reg_wr/reg_rd is high at a time.
- reg_addr and reg_wdat are stable while the strobe is high.
- The strobe stays high until reg_ack is sampled high. reg_ack in the first strobe cycle completes the transaction in one cycle.
- The strobe goes low in the cycle after ack. For back-to-back transactions it is re-asserted for the next transaction in that same cycle.
- reg_ack while no strobe is high is ignored.

## Timing
- Reset values: req_ready=1 (IDLE), busy=0, rsp_valid=0, rsp_code=0, rsp_poll_tmo=0, rsp_rdat=0, reg_wr=0, reg_rd=0, reg_addr=0, reg_wdat=0.
- All outputs are registered except req_ready, which is decoded from state.
- Latency with zero-wait ack (ack in the first strobe cycle), N_DATA_WORDS=1, first poll returns RDY: WRITE request accepted at cycle 0 → data write at cycle 1, command write at 2, status read at 3, rsp_valid at 4.
- Each BSY poll adds 1+POLL_GAP cycles.
- Worst-case polls per request: 2^N_POLL_BITS.
- rsp_ready high in the cycle rsp_valid rises completes the response in one cycle. The next request can be accepted in the following cycle.
- req_valid is ignored while busy. A request is never dropped; it is simply not accepted.
- Reset asserted mid-transaction returns to IDLE immediately and drops strobes. Any in-flight controller command is abandoned.

## Test plan
- WRITE op=2, addr=0x05, table=0, wdat=0xDEADBEEF, zero-wait ack, status RDY → bus sequence: wr DATA_ADDRESS=0xDEADBEEF, wr CMND=0x20000005, rd STAT; rsp_code=0 at cycle 4.
- READ op=1, addr=0x3, N_DATA_WORDS=2, status BSY twice then RDY, data 0x11/0x22, POLL_GAP=2 → 3 status reads spaced 3 cycles apart; rsp_rdat=0x00000022_00000011.
- Status NXM (reg_rdat=0x80000000), AUTO_ACK=1 → command write 0xF0000000 follows; rsp_code=4, rsp_poll_tmo=0.
- N_POLL_BITS=2, status always BSY → exactly 4 status reads; rsp_code=1, rsp_poll_tmo=1.
- Ack delayed 3 cycles on every transaction, rsp_ready held low 5 cycles → strobe/address stable through ack; rsp_valid held; a second req_valid is not accepted until after rsp_ready.
- rst_n pulsed low during RD_STAT → all outputs at reset values; busy=0; the next request proceeds normally.
